// File: rtl/ready_valid_fifo.sv
// First-word-fall-through byte FIFO with valid/ready handshake on both sides.
// Define RV_FIFO_COUNT_EN to expose the registered occupancy on port count.
module ready_valid_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  input  logic             output_ready
`ifdef RV_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] occ_nxt;
  logic             push;
  logic             pop;

  assign push = input_valid & input_ready;
  assign pop  = output_valid & output_ready;

  // Occupancy after this cycle's transfers; drives the registered ready/valid flags.
  always_comb begin
    occ_nxt = occ;
    if (push && !pop) begin
      occ_nxt = occ + CNT_W'(1);
    end else if (!push && pop) begin
      occ_nxt = occ - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      input_ready  <= 1'b0;
      output_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      occ          <= occ_nxt;
      input_ready  <= (occ_nxt != CNT_W'(DEPTH));
      output_valid <= (occ_nxt != '0);
    end
  end

  // Storage is deliberately left unreset; validity is tracked by occ alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= input_data;
    end
  end

  assign output_data = mem[rd_ptr];

`ifdef RV_FIFO_COUNT_EN
  assign count = occ;
`endif

endmodule

// File: tb/tb_ready_valid_fifo.sv
// Self-checking bench for ready_valid_fifo: vector table plus scoreboard-driven sequences.
module tb_ready_valid_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 128;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] input_data;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] output_data;
  logic             output_valid;
  logic             output_ready;
`ifdef RV_FIFO_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] count;
`endif

  ready_valid_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready)
`ifdef RV_FIFO_COUNT_EN
    ,
    .count        (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [WIDTH-1:0] exp_q [$];

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic             ev;
    logic             er;
    logic [WIDTH-1:0] ed;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One cycle of traffic; the queue model decides what transfers, DUT is compared to it.
  task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    logic [WIDTH-1:0] e;
    input_valid  = iv;
    input_data   = d;
    output_ready = ordy;
    @(negedge clk);
    chk("output_valid", 32'(output_valid), 32'(exp_q.size() != 0));
    chk("input_ready", 32'(input_ready), 32'(exp_q.size() < DEPTH));
`ifdef RV_FIFO_COUNT_EN
    chk("count", 32'(count), 32'(exp_q.size()));
`endif
    if (iv && exp_q.size() < DEPTH && !(ordy && exp_q.size() != 0)) begin
      exp_q.push_back(d);
    end else if (ordy && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("output_data", 32'(output_data), 32'(e));
      if (iv && exp_q.size() + 1 < DEPTH) exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b0;

    //          iv    d      ordy  ev    er    ed
    vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    vt[1]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5};
    vt[4]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vt[7]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11};
    vt[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};

    // Reset state while asserted
    #12;
    chk("rst_input_ready", 32'(input_ready), 32'd0);
    chk("rst_output_valid", 32'(output_valid), 32'd0);
`ifdef RV_FIFO_COUNT_EN
    chk("rst_count", 32'(count), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Idle after release
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      input_valid  = vt[i].iv;
      input_data   = vt[i].d;
      output_ready = vt[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_output_valid", i), 32'(output_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_input_ready", i), 32'(input_ready), 32'(vt[i].er));
      if (vt[i].ev) chk($sformatf("vec%0d_output_data", i), 32'(output_data), 32'(vt[i].ed));
    end

    // Fill to full, try an extra push, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1);

    // Full with simultaneous push and pop: pop only, then the held word enters
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 64), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1);

    // 300-word stream across the pointer wrap
    for (int i = 0; i < 300; i++) step(1'b1, 8'(i * 7 + 3), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Asynchronous reset with contents present
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 8'h50), 1'b0);
    input_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("async_input_ready", 32'(input_ready), 32'd0);
    chk("async_output_valid", 32'(output_valid), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_input_ready", 32'(input_ready), 32'd1);
    chk("post_rst_output_valid", 32'(output_valid), 32'd0);
`ifdef RV_FIFO_COUNT_EN
    chk("post_rst_count", 32'(count), 32'd0);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
